// File: rtl/syscall_unit.sv
// syscall_unit: decodes SYSCALL in writeback/commit, buffers print requests
// in a FIFO drained through a ready/valid port, drains and halts the core on
// exit, and keeps saturating cycle/instruction/syscall statistics.
//
// Ports:
//   clk, reset (async, active-high)
//   syscall_ctl, instruction, v0, a0   syscall request and operands
//   retire                              one instruction retired this cycle
//   stall, halt                         pipeline hold / core stopped (sticky)
//   out_valid, out_ready, out_kind, out_data   print FIFO head port
//   unsupported                         sticky unknown service code flag
//   cycle_count, instr_count, syscall_count    saturating statistics
module syscall_unit #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syscall_ctl,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  input  logic              retire,
  output logic              stall,
  output logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              unsupported,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  syscall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [1:0] KIND_INT  = 2'd0;
  localparam logic [1:0] KIND_CHAR = 2'd1;
  localparam logic [1:0] KIND_STR  = 2'd2;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               unsupported_q, unsupported_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ins_q, ins_d;
  logic [CNT_W-1:0]   sys_q, sys_d;
  logic [DATA_W+1:0]  mem_q [FIFO_DEPTH];

  logic               req, is_print, is_exit, full, empty;
  logic               stall_c, accept, push, pop;
  logic [1:0]         push_kind;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W+1:0]  head;

  always_comb begin
    req       = syscall_ctl && (instruction[5:0] == FUNCT_SYSCALL);
    is_print  = (v0 == DATA_W'(1)) || (v0 == DATA_W'(11)) || (v0 == DATA_W'(4));
    is_exit   = (v0 == DATA_W'(10));
    full      = (count_q == OCC_W'(FIFO_DEPTH));
    empty     = (count_q == '0);

    stall_c = 1'b1;
    case (state_q)
      ST_RUN:  stall_c = req && is_print && full;
      default: stall_c = 1'b1;
    endcase

    accept = req && (state_q == ST_RUN) && !stall_c;
    // an accepted print can never see a full FIFO, since full raises stall
    push   = accept && is_print;
    pop    = !empty && out_ready;

    push_kind = KIND_INT;
    push_data = a0;
    if (v0 == DATA_W'(11)) begin
      push_kind = KIND_CHAR;
      push_data = {{(DATA_W-8){1'b0}}, a0[7:0]};
    end else if (v0 == DATA_W'(4)) begin
      push_kind = KIND_STR;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + OCC_W'(1);
    else if (pop && !push) count_d = count_q - OCC_W'(1);

    unsupported_d = unsupported_q || (accept && !is_print && !is_exit);

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && is_exit) state_d = ST_DRAIN;
      ST_DRAIN: if (empty) state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase

    cyc_d = cyc_q;
    ins_d = ins_q;
    sys_d = sys_q;
    if (state_q != ST_HALT && cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
    if (state_q != ST_HALT && retire && ins_q != '1) ins_d = ins_q + CNT_W'(1);
    if (accept && sys_q != '1) sys_d = sys_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      unsupported_q <= 1'b0;
      cyc_q         <= '0;
      ins_q         <= '0;
      sys_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      unsupported_q <= unsupported_d;
      cyc_q         <= cyc_d;
      ins_q         <= ins_d;
      sys_q         <= sys_d;
    end
  end

  // storage needs no reset: entries are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_kind, push_data};
  end

  assign head          = mem_q[rd_ptr_q];
  assign stall         = stall_c;
  assign halt          = (state_q == ST_HALT);
  assign out_valid     = !empty;
  assign out_kind      = empty ? 2'd0 : head[DATA_W+1:DATA_W];
  assign out_data      = empty ? '0 : head[DATA_W-1:0];
  assign unsupported   = unsupported_q;
  assign cycle_count   = cyc_q;
  assign instr_count   = ins_q;
  assign syscall_count = sys_q;

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_ctl;
  logic [31:0] instruction, v0, a0;
  logic        retire, out_ready;

  logic        stall, halt, out_valid, unsupported;
  logic [1:0]  out_kind;
  logic [31:0] out_data, cycle_count, instr_count, syscall_count;

  logic        s_stall, s_halt, s_valid, s_unsup;
  logic [1:0]  s_kind;
  logic [31:0] s_data;
  logic [3:0]  s_cyc, s_ins, s_sys;

  always #5 clk = ~clk;

  syscall_unit #(.DATA_W(32), .FIFO_DEPTH(FD), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .syscall_ctl(syscall_ctl), .instruction(instruction),
    .v0(v0), .a0(a0), .retire(retire), .stall(stall), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .unsupported(unsupported), .cycle_count(cycle_count),
    .instr_count(instr_count), .syscall_count(syscall_count));

  syscall_unit #(.DATA_W(32), .FIFO_DEPTH(FD), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .syscall_ctl(syscall_ctl), .instruction(instruction),
    .v0(v0), .a0(a0), .retire(retire), .stall(s_stall), .halt(s_halt),
    .out_valid(s_valid), .out_ready(out_ready), .out_kind(s_kind),
    .out_data(s_data), .unsupported(s_unsup), .cycle_count(s_cyc),
    .instr_count(s_ins), .syscall_count(s_sys));

  // reference model: print queue, phase (0 run, 1 draining, 2 halted), raw event counts
  typedef struct { logic [1:0] k; logic [31:0] d; } ent_t;
  ent_t   q[$];
  int     mphase;
  bit     m_unsup;
  longint m_cyc, m_ins, m_sys;
  bit     exp_stall;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint capv(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit is_print_code(input logic [31:0] c);
    return c == 1 || c == 4 || c == 11;
  endfunction

  task automatic model_clear();
    q.delete();
    mphase  = 0;
    m_unsup = 0;
    m_cyc   = 0;
    m_ins   = 0;
    m_sys   = 0;
  endtask

  task automatic check_all(input bit st);
    chk("stall", stall, st);
    chk("halt", halt, mphase == 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_kind", out_kind, q.size() > 0 ? q[0].k : 2'd0);
    chk("out_data", out_data, q.size() > 0 ? q[0].d : 32'd0);
    chk("unsupported", unsupported, m_unsup);
    chk("cycle_count", cycle_count, capv(m_cyc, 32));
    chk("instr_count", instr_count, capv(m_ins, 32));
    chk("syscall_count", syscall_count, capv(m_sys, 32));
    chk("sat_cycle_count", s_cyc, capv(m_cyc, 4));
    chk("sat_instr_count", s_ins, capv(m_ins, 4));
    chk("sat_syscall_count", s_sys, capv(m_sys, 4));
  endtask

  task automatic drive(input bit ctl, input logic [31:0] code, input logic [31:0] arg);
    syscall_ctl = ctl;
    instruction = ctl ? 32'h0000_000C : 32'h0;
    v0 = code;
    a0 = arg;
  endtask

  // one clock: check pre-edge outputs against the model, then advance the model
  task automatic step();
    bit req, prt, acc, pop, was_empty;
    ent_t e;
    #1;
    req = syscall_ctl && instruction[5:0] == 6'h0C;
    prt = is_print_code(v0);
    exp_stall = (mphase != 0) || (req && prt && q.size() == FD);
    check_all(exp_stall);
    acc = req && !exp_stall;
    was_empty = (q.size() == 0);
    pop = !was_empty && out_ready;
    @(posedge clk);
    if (mphase != 2) begin
      m_cyc++;
      if (retire) m_ins++;
    end
    if (acc) m_sys++;
    if (pop) void'(q.pop_front());
    if (acc && prt) begin
      e.k = (v0 == 1) ? 2'd0 : (v0 == 11) ? 2'd1 : 2'd2;
      e.d = (v0 == 11) ? {24'd0, a0[7:0]} : a0;
      q.push_back(e);
    end
    if (acc && !prt && v0 != 10) m_unsup = 1;
    if (mphase == 0 && acc && v0 == 10) mphase = 1;
    else if (mphase == 1 && was_empty) mphase = 2;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    retire    = 0;
    out_ready = 0;
    reset     = 1;
    #1;
    model_clear();
    check_all(1'b0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [31:0] codes [8];
    codes = '{1, 4, 11, 7, 1, 0, 4, 11};

    do_reset();

    // single int print
    drive(1, 1, 42);
    out_ready = 1;
    step();
    drive(0, 0, 0);
    repeat (3) step();
    chk("sys_after_print", syscall_count, 1);
    chk("unsup_after_print", unsupported, 0);

    // fill to full, stall on the ninth, release by popping
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, i);
      if (i == 8) begin
        #1;
        chk("stall_ninth", stall, 1);
      end
      step();
      guard = 0;
      while (exp_stall && guard < 20) begin
        if (i == 8 && guard == 2) out_ready = 1;
        step();
        guard++;
      end
      chk("stall_bound", guard < 20, 1);
    end
    drive(0, 0, 0);
    out_ready = 1;
    repeat (12) step();
    chk("drained_empty", out_valid, 0);

    // char print truncates to the low byte
    out_ready = 0;
    drive(1, 11, 32'h1234_5641);
    step();
    drive(0, 0, 0);
    #1;
    chk("char_kind", out_kind, 1);
    chk("char_data", out_data, 32'h41);
    out_ready = 1;
    step();

    // unsupported code: no push, no stall, counted
    drive(1, 7, 99);
    step();
    drive(0, 0, 0);
    step();
    chk("unsup_set", unsupported, 1);
    chk("unsup_no_push", out_valid, 0);
    drive(1, 4, 32'hCAFE_0000);
    step();
    drive(0, 0, 0);
    repeat (2) step();

    // randomized traffic, never exiting
    for (int c = 0; c < 400; c++) begin
      if (!exp_stall) begin
        syscall_ctl = $urandom_range(0, 1);
        instruction = $urandom;
        if ($urandom_range(0, 3) != 0) instruction[5:0] = 6'h0C;
        v0 = codes[$urandom_range(0, 7)];
        a0 = $urandom;
      end
      out_ready = ($urandom_range(0, 2) == 0);
      retire    = $urandom_range(0, 1);
      step();
    end

    // saturation of the 4-bit counter instance
    do_reset();
    retire = 1;
    repeat (20) step();
    chk("sat_cycle_15", s_cyc, 15);
    chk("sat_instr_15", s_ins, 15);

    // exit with three pending prints
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 100 + i);
      step();
    end
    drive(1, 10, 0);
    step();
    drive(0, 0, 0);
    repeat (3) step();
    chk("drain_halt_low", halt, 0);
    chk("drain_stall_high", stall, 1);
    out_ready = 1;
    guard = 0;
    while (!halt && guard < 20) begin
      step();
      guard++;
    end
    chk("halt_bound", guard < 20, 1);
    repeat (5) step();
    chk("halt_sticky", halt, 1);

    // asynchronous reset from HALT
    reset = 1;
    #1;
    chk("rst_halt", halt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_sys", syscall_count, 0);
    model_clear();
    @(negedge clk);
    reset = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Synthesizable, parametrised system-call unit for the MIPS CPU; replaces the simulation-only syscall handler in the writeback/commit stage. Decodes SYSCALL (funct 0x0C) using the service code in $v0. Print requests are buffered in an output FIFO drained by a host/testbench port. Exit drains the FIFO and then halts the core. The unit also keeps saturating cycle, retired-instruction and syscall statistics counters, and stalls the pipeline when a request cannot complete.

## Interface
Parameters:
- DATA_W, 32, width of $v0/$a0 and of FIFO payload
- FIFO_DEPTH, 8, print FIFO entries; power of two, ≥2
- CNT_W, 32, width of each statistics counter

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- syscall_ctl  in  1  control says current instruction is a syscall candidate
- instruction  in  32  current instruction; funct = instruction[5:0]
- v0  in  DATA_W  service code
- a0  in  DATA_W  argument
- retire  in  1  one instruction retired this cycle
- stall  out  1  hold pipeline; inputs must stay stable while high
- halt  out  1  core stopped (sticky until reset)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_kind  out  2  0 = int, 1 = char, 2 = string-address
- out_data  out  DATA_W  head payload
- unsupported  out  1  sticky; an unknown service code was seen
- cycle_count  out  CNT_W  cycles since reset, excluding halted cycles
- instr_count  out  CNT_W  retired instructions
- syscall_count  out  CNT_W  accepted syscalls

## Operation
- Request: req = syscall_ctl && instruction[5:0]==6'h0C. A request is accepted on a cycle where req && !stall && state==RUN.
- Service codes:
  - v0==1: push {0, a0}.
  - v0==11: push {1, {a0[7:0] zero-extended}}.
  - v0==4: push {2, a0}.
  - v0==10: accept, then go to DRAIN.
  - Any other code: accept as a no-op and set unsupported.
- FSM states:
  - RUN: normal operation.
  - DRAIN: on entry, stall=1 and no accepts. When the FIFO is empty, go to HALT.
  - HALT: stall=1, halt=1, terminal. Only reset leaves HALT.
- Stall (combinational):
  - In RUN: stall = req && print-code && fifo_full.
  - In DRAIN and HALT: stall = 1.
  - A non-print request never stalls in RUN.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
  - Push occurs only when not full. Full blocks a push even if a pop happens the same cycle; the push succeeds the following cycle.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
  - out_valid = count!=0. out_kind/out_data are the head entry.
  - The FIFO keeps draining in DRAIN and in HALT.
- Counters:
  - Each counter saturates at all-ones and never wraps.
  - cycle_count increments every cycle when state!=HALT.
  - instr_count increments on retire when state!=HALT.
  - syscall_count increments on every accepted request, including exit and unsupported codes.
- unsupported: sticky; cleared only by reset.

## Timing
- Reset values:
  - stall=0, halt=0, out_valid=0, out_kind=0, out_data=0, unsupported=0.
  - All counters 0; FIFO empty; state=RUN.
- Print latency: accept at edge N; out_valid is high after edge N (visible in cycle N+1) if the FIFO was empty. No combinational in-to-out path on the data.
- Exit latency:
  - Accept at edge N → state=DRAIN.
  - If the FIFO is empty, HALT at edge N+1 and halt visible in cycle N+2.
  - Otherwise HALT is reached one edge after the FIFO becomes empty.
- Stall→release: once full with out_ready=1, one pop edge frees a slot; stall drops the next cycle and the push lands on the following edge.
- Reset mid-operation: asynchronous clear at any state. The FIFO contents are discarded. halt and stall drop immediately.
- syscall_ctl held high across several cycles with stall=0 is treated as one request per cycle. The pipeline must present each syscall for one accepted cycle only.

## Test plan
- Reset, then v0=1, a0=42 request, out_ready=1 → one beat with kind=0, data=42. Then syscall_count=1, unsupported=0.
- FIFO_DEPTH=8, out_ready=0, 9 print requests with a0=0..8 → the first 8 are accepted and stall=1 on the 9th. Raise out_ready → stall drops after one pop. Data emerges as 0..8 in order, and the pointers wrap correctly.
- v0=11, a0=0x1234_5641 → kind=1, data=0x41.
- Fill 3 entries, then exit (v0=10) with out_ready=0:
  - state stays DRAIN, halt=0, stall=1.
  - Release out_ready → 3 beats, then halt=1 one cycle after empty.
  - cycle_count and instr_count freeze from then on.
- v0=7 → unsupported=1, no FIFO push, no stall, syscall_count increments. A later valid print still works.
- CNT_W=4, run 20 cycles with retire=1 → cycle_count=15 and instr_count=15, saturated. Assert reset mid-run → all outputs return to 0 asynchronously.
